// File: rtl/mem_pipe.sv
// Parametrised single-port memory with a pipelined read path,
// a post-reset clear sweep and read/write collision detection.
module mem_pipe #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 5,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic                  read,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  ready,
    output logic                  collision,
    output logic [7:0]            collision_count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    clr_en;
    logic                    rd_acc;
    logic                    wr_acc;
    logic                    col_acc;

    logic                    col_q, col_d;
    logic [7:0]              cnt_q, cnt_d;

    logic [READ_LATENCY-1:0] pv_q;
    logic [DATA_WIDTH-1:0]   pd_q [READ_LATENCY];

    // Request decode is only meaningful once the clear sweep is done.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        clr_en  = 1'b0;
        rd_acc  = 1'b0;
        wr_acc  = 1'b0;
        col_acc = 1'b0;
        unique case (state_q)
            CLEAR: begin
                clr_en = 1'b1;
                ptr_d  = ptr_q + 1'b1;
                if (ptr_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                rd_acc  = read && !write;
                wr_acc  = write && !read;
                col_acc = read && write;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            if (clr_en) begin
                mem_q[ptr_q] <= '0;
            end else if (wr_acc) begin
                mem_q[addr] <= data_in;
            end
        end
    end

    always_comb begin
        col_d = col_acc;
        cnt_d = cnt_q;
        if (col_acc && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            col_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            col_q <= col_d;
            cnt_q <= cnt_d;
        end
    end

    // Data stages only load behind a valid, so the last stage holds.
    always_ff @(posedge clk) begin
        if (!rst_) begin
            pv_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pd_q[i] <= '0;
            end
        end else begin
            pv_q[0] <= rd_acc;
            if (rd_acc) begin
                pd_q[0] <= mem_q[addr];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                pv_q[i] <= pv_q[i-1];
                if (pv_q[i-1]) begin
                    pd_q[i] <= pd_q[i-1];
                end
            end
        end
    end

    assign data_out        = pd_q[READ_LATENCY-1];
    assign data_valid      = pv_q[READ_LATENCY-1];
    assign ready           = rst_ && (state_q == IDLE);
    assign collision       = col_q;
    assign collision_count = cnt_q;

endmodule

// File: tb/tb_mem_pipe.sv
// Directed bench for mem_pipe: one instance at latency 1,
// one at latency 3, both driven by the same stimulus.
module tb_mem_pipe;

    logic       clk;
    logic       rst_;
    logic       rd;
    logic       wr;
    logic [4:0] addr;
    logic [7:0] din;

    logic [7:0] do1, do3;
    logic       dv1, dv3;
    logic       rdy1, rdy3;
    logic       col1, col3;
    logic [7:0] cnt1, cnt3;

    int errors;
    int checks;

    mem_pipe u_l1 (
        .clk             (clk),
        .rst_            (rst_),
        .read            (rd),
        .write           (wr),
        .addr            (addr),
        .data_in         (din),
        .data_out        (do1),
        .data_valid      (dv1),
        .ready           (rdy1),
        .collision       (col1),
        .collision_count (cnt1)
    );

    mem_pipe #(.READ_LATENCY(3)) u_l3 (
        .clk             (clk),
        .rst_            (rst_),
        .read            (rd),
        .write           (wr),
        .addr            (addr),
        .data_in         (din),
        .data_out        (do3),
        .data_valid      (dv3),
        .ready           (rdy3),
        .collision       (col3),
        .collision_count (cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        rd   = 1'b0;
        wr   = 1'b0;
        addr = '0;
        din  = '0;
    endtask

    task automatic test_reset();
        rst_ = 1'b0;
        idle_in();
        tick();
        tick();
        checks++;
        if (rdy1 !== 1'b0 || rdy3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got=%b/%b want=0/0", rdy1, rdy3);
        end
        checks++;
        if (dv1 !== 1'b0 || dv3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got=%b/%b want=0/0", dv1, dv3);
        end
        checks++;
        if (do1 !== 8'h00 || do3 !== 8'h00) begin
            errors++;
            $display("FAIL reset_data got=%h/%h want=00/00", do1, do3);
        end
        checks++;
        if (col1 !== 1'b0 || cnt1 !== 8'h00) begin
            errors++;
            $display("FAIL reset_col got=%b cnt=%h want=0 cnt=00", col1, cnt1);
        end
    endtask

    task automatic test_clear_sweep();
        int n1;
        int n3;
        n1 = 0;
        n3 = 0;
        rst_ = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            tick();
            checks++;
            if (rdy1 !== (e == 32) || rdy3 !== (e == 32)) begin
                errors++;
                $display("FAIL sweep_ready e=%0d got=%b/%b want=%b",
                         e, rdy1, rdy3, (e == 32));
            end
        end
        for (int c = 0; c < 34; c++) begin
            rd   = (c < 32);
            addr = c[4:0];
            tick();
            n1 += int'(dv1);
            n3 += int'(dv3);
            checks++;
            if (dv1 !== (c < 32) || (c < 32 && do1 !== 8'h00)) begin
                errors++;
                $display("FAIL sweep_rd_l1 c=%0d got=%b/%h want=%b/00",
                         c, dv1, do1, (c < 32));
            end
            checks++;
            if (dv3 !== (c >= 2) || (c >= 2 && do3 !== 8'h00)) begin
                errors++;
                $display("FAIL sweep_rd_l3 c=%0d got=%b/%h want=%b/00",
                         c, dv3, do3, (c >= 2));
            end
        end
        idle_in();
        checks++;
        if (n1 != 32 || n3 != 32) begin
            errors++;
            $display("FAIL sweep_pulses got=%0d/%0d want=32/32", n1, n3);
        end
    endtask

    task automatic test_latency();
        wr   = 1'b1;
        addr = 5'd5;
        din  = 8'hA5;
        tick();
        wr = 1'b0;
        rd = 1'b1;
        tick();
        checks++;
        if (dv1 !== 1'b1 || do1 !== 8'hA5) begin
            errors++;
            $display("FAIL lat_l1 got=%b/%h want=1/a5", dv1, do1);
        end
        checks++;
        if (dv3 !== 1'b0) begin
            errors++;
            $display("FAIL lat_l3_k1 got=%b want=0", dv3);
        end
        rd = 1'b0;
        tick();
        checks++;
        if (dv1 !== 1'b0 || do1 !== 8'hA5 || dv3 !== 1'b0) begin
            errors++;
            $display("FAIL lat_k2 got=%b/%h dv3=%b want=0/a5 dv3=0",
                     dv1, do1, dv3);
        end
        tick();
        checks++;
        if (dv3 !== 1'b1 || do3 !== 8'hA5) begin
            errors++;
            $display("FAIL lat_l3_k3 got=%b/%h want=1/a5", dv3, do3);
        end
        tick();
        checks++;
        if (dv3 !== 1'b0 || do3 !== 8'hA5) begin
            errors++;
            $display("FAIL lat_l3_hold got=%b/%h want=0/a5", dv3, do3);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 32; i++) begin
            wr   = 1'b1;
            addr = i[4:0];
            din  = 8'(i + 16);
            tick();
        end
        idle_in();
        for (int c = 0; c < 34; c++) begin
            rd   = (c < 32);
            addr = c[4:0];
            tick();
            checks++;
            if (dv1 !== (c < 32) || (c < 32 && do1 !== 8'(c + 16))) begin
                errors++;
                $display("FAIL b2b_l1 c=%0d got=%b/%h want=%b/%h",
                         c, dv1, do1, (c < 32), 8'(c + 16));
            end
            checks++;
            if (dv3 !== (c >= 2) || (c >= 2 && do3 !== 8'(c + 14))) begin
                errors++;
                $display("FAIL b2b_l3 c=%0d got=%b/%h want=%b/%h",
                         c, dv3, do3, (c >= 2), 8'(c + 14));
            end
        end
        idle_in();
    endtask

    task automatic test_collision();
        rd   = 1'b1;
        wr   = 1'b1;
        addr = 5'd3;
        din  = 8'hFF;
        tick();
        checks++;
        if (col1 !== 1'b1 || cnt1 !== 8'd1 || cnt3 !== 8'd1 || dv1 !== 1'b0) begin
            errors++;
            $display("FAIL col_once got=%b cnt=%h/%h dv=%b want=1 01/01 0",
                     col1, cnt1, cnt3, dv1);
        end
        idle_in();
        tick();
        checks++;
        if (col1 !== 1'b0 || cnt1 !== 8'd1) begin
            errors++;
            $display("FAIL col_fall got=%b cnt=%h want=0 01", col1, cnt1);
        end
        tick();
        checks++;
        if (dv3 !== 1'b0) begin
            errors++;
            $display("FAIL col_no_valid_l3 got=%b want=0", dv3);
        end
        rd   = 1'b1;
        addr = 5'd3;
        tick();
        checks++;
        if (dv1 !== 1'b1 || do1 !== 8'h13) begin
            errors++;
            $display("FAIL col_prior_l1 got=%b/%h want=1/13", dv1, do1);
        end
        rd = 1'b0;
        tick();
        tick();
        checks++;
        if (dv3 !== 1'b1 || do3 !== 8'h13) begin
            errors++;
            $display("FAIL col_prior_l3 got=%b/%h want=1/13", dv3, do3);
        end
        rd   = 1'b1;
        wr   = 1'b1;
        addr = 5'd3;
        din  = 8'hFF;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 253) begin
                checks++;
                if (cnt1 !== 8'd254) begin
                    errors++;
                    $display("FAIL col_cnt254 got=%h want=fe", cnt1);
                end
            end
        end
        checks++;
        if (cnt1 !== 8'hFF || cnt3 !== 8'hFF || col1 !== 1'b1) begin
            errors++;
            $display("FAIL col_sat got=%h/%h col=%b want=ff/ff 1",
                     cnt1, cnt3, col1);
        end
        idle_in();
        tick();
        checks++;
        if (col1 !== 1'b0 || cnt1 !== 8'hFF) begin
            errors++;
            $display("FAIL col_end got=%b cnt=%h want=0 ff", col1, cnt1);
        end
    endtask

    task automatic test_clear_requests();
        rst_ = 1'b0;
        tick();
        checks++;
        if (cnt1 !== 8'h00 || col1 !== 1'b0) begin
            errors++;
            $display("FAIL creq_reset got=%h/%b want=00/0", cnt1, col1);
        end
        rst_ = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            idle_in();
            if (e == 10) begin
                wr = 1'b1; addr = 5'd2; din = 8'h77;
            end
            if (e == 12) begin
                rd = 1'b1; wr = 1'b1; addr = 5'd2; din = 8'h99;
            end
            if (e == 14) begin
                rd = 1'b1; addr = 5'd2;
            end
            if (e == 32) begin
                wr = 1'b1; addr = 5'd4; din = 8'h55;
            end
            tick();
            if (e == 12) begin
                checks++;
                if (col1 !== 1'b0) begin
                    errors++;
                    $display("FAIL creq_col got=%b want=0", col1);
                end
            end
            if (e == 14) begin
                checks++;
                if (dv1 !== 1'b0) begin
                    errors++;
                    $display("FAIL creq_read got=%b want=0", dv1);
                end
            end
        end
        idle_in();
        checks++;
        if (cnt1 !== 8'h00 || rdy1 !== 1'b1) begin
            errors++;
            $display("FAIL creq_cnt got=%h rdy=%b want=00 1", cnt1, rdy1);
        end
        rd   = 1'b1;
        addr = 5'd2;
        tick();
        checks++;
        if (dv1 !== 1'b1 || do1 !== 8'h00) begin
            errors++;
            $display("FAIL creq_addr2 got=%b/%h want=1/00", dv1, do1);
        end
        addr = 5'd4;
        tick();
        checks++;
        if (dv1 !== 1'b1 || do1 !== 8'h00) begin
            errors++;
            $display("FAIL creq_addr4 got=%b/%h want=1/00", dv1, do1);
        end
        idle_in();
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        wr   = 1'b1;
        addr = 5'd7;
        din  = 8'h5A;
        tick();
        wr = 1'b0;
        rd = 1'b1;
        tick();
        rd = 1'b0;
        tick();
        tick();
        checks++;
        if (do1 !== 8'h5A || do3 !== 8'h5A) begin
            errors++;
            $display("FAIL mid_pre got=%h/%h want=5a/5a", do1, do3);
        end
        rd = 1'b1;
        tick();
        rd   = 1'b0;
        rst_ = 1'b0;
        tick();
        checks++;
        if (dv3 !== 1'b0 || do3 !== 8'h00 || do1 !== 8'h00) begin
            errors++;
            $display("FAIL mid_rst got=%b/%h do1=%h want=0/00 do1=00",
                     dv3, do3, do1);
        end
        checks++;
        if (rdy1 !== 1'b0 || cnt3 !== 8'h00) begin
            errors++;
            $display("FAIL mid_rdy got=%b cnt=%h want=0 00", rdy1, cnt3);
        end
        rst_ = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            checks++;
            if (dv3 !== 1'b0 || dv1 !== 1'b0 || rdy3 !== 1'b0) begin
                errors++;
                $display("FAIL mid_stale e=%0d got=%b/%b rdy=%b want=0/0 0",
                         e, dv1, dv3, rdy3);
            end
        end
        rst_ = 1'b0;
        tick();
        rst_ = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            tick();
            checks++;
            if (rdy1 !== (e == 32) || rdy3 !== (e == 32)) begin
                errors++;
                $display("FAIL mid_sweep e=%0d got=%b/%b want=%b",
                         e, rdy1, rdy3, (e == 32));
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_clear_sweep();
        test_latency();
        test_back_to_back();
        test_collision();
        test_clear_requests();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
